gray_enc_arbiter: RTL
=====================

GRAY_ENC_ARBITER -- requirements
Module: gray_enc_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4: the number of requesters sharing one encoder, legal range 2..8.
REQ-002 The block SHALL have derived localparam IdWidth, equal to $clog2(NumReq): the width of the requester index.
REQ-003 The block SHALL have one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  SHALL be the asynchronous active-high reset.
REQ-006 req_valid_i  input  NumReq  SHALL mean that requester k presents a binary operand.
REQ-007 req_bin_i  input  NumReq*4  SHALL carry the 4-bit binary operand for requester k in slice [4k+3:4k].
REQ-008 req_ready_o  output  NumReq  SHALL be a one-hot-or-zero grant; bit k high SHALL mean requester k's operand is accepted this cycle.
REQ-009 gray_valid_o  output  1  SHALL mean that the result register holds a valid result.
REQ-010 gray_o  output  4  SHALL carry the Gray-coded result.
REQ-011 gray_id_o  output  IdWidth  SHALL carry the index of the requester that produced gray_o.
REQ-012 gray_ready_i  input  1  SHALL mean that the downstream consumer accepts the result this cycle.

Function
REQ-013 The FSM SHALL have exactly two states: ST_EMPTY (result register empty) and ST_FULL (result register holds unconsumed data).
REQ-014 The slot SHALL be free when state==ST_EMPTY, or when state==ST_FULL and gray_ready_i==1.
REQ-015 A grant SHALL occur only when the slot is free and at least one req_valid_i bit is set.
REQ-016 Arbitration SHALL be round-robin: search starts at prio_q and proceeds upward modulo NumReq; the first valid requester wins.
REQ-017 After a grant to requester k, prio_q SHALL become (k+1) mod NumReq; with no grant, prio_q SHALL hold.
REQ-018 req_ready_o SHALL be combinational from req_valid_i, state, gray_ready_i and prio_q, and SHALL never assert for a requester whose req_valid_i is low.
REQ-019 On a grant, the granted operand SHALL pass through one bin2gray instance; gray_o and gray_id_o SHALL be registered on the same edge, giving 1-cycle latency from acceptance to gray_valid_o.
REQ-020 The result SHALL be gray_o = bin ^ (bin >> 1) for all 16 codes.
REQ-021 ST_EMPTY SHALL go to ST_FULL on a grant, otherwise stay in ST_EMPTY.
REQ-022 ST_FULL SHALL stay in ST_FULL with new data when gray_ready_i==1 and a grant occurs in the same cycle; this provides back-to-back throughput of one result per cycle.
REQ-023 ST_FULL SHALL go to ST_EMPTY when gray_ready_i==1 and there is no grant.
REQ-024 ST_FULL SHALL hold when gray_ready_i==0; gray_o and gray_id_o SHALL remain stable and req_ready_o SHALL be all-zero.
REQ-025 gray_valid_o SHALL equal (state==ST_FULL).
REQ-026 A requester SHALL be able to drop req_valid_i without having been granted; no grant is remembered.

Reset
REQ-027 When rst_i is asserted, state SHALL be ST_EMPTY, prio_q 0, gray_valid_o 0, gray_o 4'b0000 and gray_id_o 0, immediately and independently of clk_i.
REQ-028 Reset mid-operation SHALL discard any held result, and no result SHALL be emitted for it.
REQ-029 While rst_i is high, req_ready_o SHALL be all-zero.
REQ-030 The first grant SHALL be possible on the first rising clk_i edge after rst_i deasserts.

Structure
REQ-031 The shared package gray_arb_pkg SHALL hold the state enum (ST_EMPTY, ST_FULL), the constant GrayWidth=4 and the constant NumReqMax=8.
REQ-032 The block SHALL instantiate exactly one existing bin2gray sub-module, fed by the granted operand mux.
REQ-033 The round-robin selector SHALL be written inline in this block, with no further sub-modules.

Verification
REQ-034 With NumReq=4, a single request k=2, bin 4'b0101, and gray_ready_i=1: req_ready_o SHALL be 4'b0100; next cycle gray_valid_o=1, gray_o=4'b0111, gray_id_o=2.
REQ-035 With all four valid continuously from reset and gray_ready_i=1: the grant order SHALL be 0,1,2,3,0,1 with one result per cycle and no bubbles.
REQ-036 With gray_ready_i held 0 for 5 cycles while the result is 4'b1100: gray_o SHALL stay 4'b1100 and req_ready_o SHALL stay 0; on release the next grant SHALL occur in the same cycle as consumption.
REQ-037 Sweeping bin 0..15 through requester 1: every gray_o SHALL match bin^(bin>>1), e.g. 4'b1000 -> 4'b1100 and 4'b1111 -> 4'b1000.
REQ-038 Asserting rst_i asynchronously (between clock edges) while in ST_FULL: gray_valid_o SHALL fall without a clock edge, and after release with requesters 1 and 3 valid the first grant SHALL go to 1.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// Shared types and constants for the Gray-encoder arbiter.
package gray_arb_pkg;

    // Result-register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int unsigned GrayWidth = 4;
    localparam int unsigned NumReqMax = 8;

endpackage

// File: rtl/bin2gray.sv
// Purely combinational binary-to-Gray converter.
module bin2gray #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] i_bin,
    output logic [Width-1:0] o_gray
);

    // Each Gray bit is the XOR of adjacent binary bits.
    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_enc_arbiter.sv
// Round-robin arbiter that lets NumReq requesters share one binary-to-Gray
// encoder, with a single-entry result register that supports one result per
// cycle when the consumer keeps up.
module gray_enc_arbiter
    import gray_arb_pkg::*;
#(
    parameter  int unsigned NumReq  = 4,
    localparam int unsigned IdWidth = $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*GrayWidth-1:0]   req_bin_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic                          gray_valid_o,
    output logic [GrayWidth-1:0]          gray_o,
    output logic [IdWidth-1:0]            gray_id_o,
    input  logic                          gray_ready_i
);

    if (NumReq < 2 || NumReq > NumReqMax) begin : g_bad_num_req
        $error("gray_enc_arbiter: NumReq out of range");
    end

    state_e               r_state;
    state_e               w_state_next;
    logic [IdWidth-1:0]   r_prio;
    logic [IdWidth-1:0]   w_prio_next;
    logic [GrayWidth-1:0] r_gray;
    logic [IdWidth-1:0]   r_id;

    logic                 w_free;
    logic                 w_hit;
    logic                 w_grant;
    logic [IdWidth-1:0]   w_gnt_id;
    logic [GrayWidth-1:0] w_bin;
    logic [GrayWidth-1:0] w_gray;

    // Slot is free when empty, or when the held result is consumed this cycle.
    assign w_free  = (r_state == ST_EMPTY) || gray_ready_i;
    // Reset gating keeps grants off while rst_i is high, even though the
    // state already reads empty.
    assign w_grant = w_free && w_hit && !rst_i;

    // Round-robin search from r_prio upward, wrapping modulo NumReq.
    always_comb begin
        int unsigned        idx;
        logic [IdWidth-1:0] cand;
        w_hit    = 1'b0;
        w_gnt_id = '0;
        idx      = 0;
        cand     = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx  = (32'(r_prio) + i) % NumReq;
            cand = IdWidth'(idx);
            if (!w_hit && req_valid_i[cand]) begin
                w_hit    = 1'b1;
                w_gnt_id = cand;
            end
        end
    end

    // One-hot grant vector and granted-operand mux.
    always_comb begin
        req_ready_o = '0;
        w_bin       = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (w_gnt_id == IdWidth'(k)) begin
                req_ready_o[k] = w_grant;
                w_bin          = req_bin_i[k*GrayWidth +: GrayWidth];
            end
        end
    end

    bin2gray #(
        .Width (GrayWidth)
    ) u_bin2gray (
        .i_bin  (w_bin),
        .o_gray (w_gray)
    );

    // Next-state and next-priority decode.
    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio;
        if (w_grant) begin
            w_prio_next = (w_gnt_id == IdWidth'(NumReq - 1)) ? '0 : w_gnt_id + 1'b1;
        end
        unique case (r_state)
            ST_EMPTY: if (w_grant) w_state_next = ST_FULL;
            ST_FULL:  if (gray_ready_i) w_state_next = w_grant ? ST_FULL : ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    // State, priority and result registers; result loads only on a grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
            r_prio  <= '0;
            r_gray  <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_next;
            r_prio  <= w_prio_next;
            if (w_grant) begin
                r_gray <= w_gray;
                r_id   <= w_gnt_id;
            end
        end
    end

    assign gray_valid_o = (r_state == ST_FULL);
    assign gray_o       = r_gray;
    assign gray_id_o    = r_id;

endmodule
